// File: rtl/mult_div_unit_pkg.sv
// Shared MDU opcode/state macros plus a package mirroring them as typed constants.
// MDU_MADD_EN (in mult_div_unit) turns on the madd/maddu/msub/msubu opcodes.
`ifndef MULT_DIV_UNIT_PKG_SV
`define MULT_DIV_UNIT_PKG_SV

`define MDUOP_SIZE  4
`define MDUOP_NONE  4'd0
`define MDUOP_MULT  4'd1
`define MDUOP_MULTU 4'd2
`define MDUOP_DIV   4'd3
`define MDUOP_DIVU  4'd4
`define MDUOP_MADD  4'd5
`define MDUOP_MADDU 4'd6
`define MDUOP_MSUB  4'd7
`define MDUOP_MSUBU 4'd8

`define MDU_STATE_IDLE 1'b0
`define MDU_STATE_BUSY 1'b1

package mult_div_unit_pkg;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_NONE  = `MDUOP_NONE;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_MULT  = `MDUOP_MULT;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_MULTU = `MDUOP_MULTU;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_DIV   = `MDUOP_DIV;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_DIVU  = `MDUOP_DIVU;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_MADD  = `MDUOP_MADD;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_MADDU = `MDUOP_MADDU;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_MSUB  = `MDUOP_MSUB;
  localparam logic [`MDUOP_SIZE-1:0] MDUOP_MSUBU = `MDUOP_MSUBU;

  localparam logic [0:0] MDU_STATE_IDLE = `MDU_STATE_IDLE;
  localparam logic [0:0] MDU_STATE_BUSY = `MDU_STATE_BUSY;

  function automatic logic mdu_is_div(input logic [`MDUOP_SIZE-1:0] op);
    return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
  endfunction
endpackage

`endif

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; results commit after a fixed busy window.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (accumulate into {HI,LO}).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [`MDUOP_SIZE-1:0] operation,
  input  logic [31:0]            operand1,
  input  logic [31:0]            operand2,
  input  logic                   write_hi,
  input  logic                   write_lo,
  input  logic [31:0]            write_data,
  output logic                   busy,
  output logic [31:0]            HI,
  output logic [31:0]            LO
);
  localparam int MAXC  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo, r_hi_pend, r_lo_pend;

  logic             w_valid;
  logic [CNT_W-1:0] w_cycles;
  logic [31:0]      w_hi_pend, w_lo_pend;
  logic signed [63:0] w_prod_s;
  logic [63:0]      w_prod_u, w_acc;

  assign w_prod_s = $signed({{32{operand1[31]}}, operand1}) * $signed({{32{operand2[31]}}, operand2});
  assign w_prod_u = {32'b0, operand1} * {32'b0, operand2};
  assign w_acc    = {r_hi, r_lo};

  // Divide by zero keeps HI/LO by committing their current values as the result.
  always_comb begin
    w_valid   = 1'b0;
    w_cycles  = mdu_is_div(operation) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    w_hi_pend = r_hi;
    w_lo_pend = r_lo;
    case (operation)
      MDUOP_MULT: begin
        w_valid = 1'b1;
        {w_hi_pend, w_lo_pend} = w_prod_s;
      end
      MDUOP_MULTU: begin
        w_valid = 1'b1;
        {w_hi_pend, w_lo_pend} = w_prod_u;
      end
      MDUOP_DIV: begin
        w_valid = 1'b1;
        if (operand2 != 32'd0) begin
          // The one signed overflow case is pinned explicitly rather than left to '/'.
          if (operand1 == 32'h8000_0000 && operand2 == 32'hFFFF_FFFF) begin
            w_lo_pend = 32'h8000_0000;
            w_hi_pend = 32'd0;
          end else begin
            w_lo_pend = $signed(operand1) / $signed(operand2);
            w_hi_pend = $signed(operand1) % $signed(operand2);
          end
        end
      end
      MDUOP_DIVU: begin
        w_valid = 1'b1;
        if (operand2 != 32'd0) begin
          w_lo_pend = operand1 / operand2;
          w_hi_pend = operand1 % operand2;
        end
      end
`ifdef MDU_MADD_EN
      MDUOP_MADD: begin
        w_valid = 1'b1;
        {w_hi_pend, w_lo_pend} = w_acc + $unsigned(w_prod_s);
      end
      MDUOP_MADDU: begin
        w_valid = 1'b1;
        {w_hi_pend, w_lo_pend} = w_acc + w_prod_u;
      end
      MDUOP_MSUB: begin
        w_valid = 1'b1;
        {w_hi_pend, w_lo_pend} = w_acc - $unsigned(w_prod_s);
      end
      MDUOP_MSUBU: begin
        w_valid = 1'b1;
        {w_hi_pend, w_lo_pend} = w_acc - w_prod_u;
      end
`endif
      default: w_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MDU_STATE_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hi_pend <= '0;
      r_lo_pend <= '0;
    end else begin
      case (r_state)
        MDU_STATE_IDLE: begin
          if (start) begin
            if (w_valid) begin
              r_hi_pend <= w_hi_pend;
              r_lo_pend <= w_lo_pend;
              r_cnt     <= w_cycles;
              r_state   <= MDU_STATE_BUSY;
            end
          end else begin
            if (write_hi) r_hi <= write_data;
            if (write_lo) r_lo <= write_data;
          end
        end
        default: begin
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_hi_pend;
            r_lo    <= r_lo_pend;
            r_cnt   <= '0;
            r_state <= MDU_STATE_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy = (r_state == MDU_STATE_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases then randomized ops vs. an arithmetic model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, write_hi, write_lo, busy;
  logic [3:0]  operation;
  logic [31:0] operand1, operand2, write_data, HI, LO;

  exp_t        q[$];
  logic [31:0] m_hi, m_lo;
  int          n_cmp = 0;
  int          n_err = 0;

  mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand1(operand1), .operand2(operand2), .write_hi(write_hi),
    .write_lo(write_lo), .write_data(write_data), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: HI/LO as plain 64-bit arithmetic over the architectural state.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output exp_t e);
    longint          sa, sb;
    longint unsigned ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    acc = {m_hi, m_lo};
    e.cyc = MULT_CYCLES;
    case (op)
      MDUOP_MULT:  {m_hi, m_lo} = sa * sb;
      MDUOP_MULTU: {m_hi, m_lo} = ua * ub;
      MDUOP_DIV: begin
        e.cyc = DIV_CYCLES;
        if (b != 0) begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      MDUOP_DIVU: begin
        e.cyc = DIV_CYCLES;
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      MDUOP_MADD:  {m_hi, m_lo} = acc + 64'(sa * sb);
      MDUOP_MADDU: {m_hi, m_lo} = acc + ua * ub;
      MDUOP_MSUB:  {m_hi, m_lo} = acc - 64'(sa * sb);
      MDUOP_MSUBU: {m_hi, m_lo} = acc - ua * ub;
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
  endtask

  task automatic wait_idle(input bit poke);
    int n;
    n = 0;
    while (busy && n < 64) begin
      if (poke && n == 1) begin
        start = 1'b1; operation = MDUOP_MULT; operand1 = 32'd3; operand2 = 32'd3;
        write_hi = 1'b1; write_data = 32'hAAAA;
      end else begin
        start = 1'b0; write_hi = 1'b0; operation = MDUOP_NONE;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; write_hi = 1'b0; operation = MDUOP_NONE;
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_t e;
    model(op, a, b, e);
    q.push_back(e);
    start = 1'b1; operation = op; operand1 = a; operand2 = b;
    @(posedge clk); #1;
    start = 1'b0; operation = MDUOP_NONE; write_hi = 1'b0; write_lo = 1'b0;
    wait_idle(poke);
  endtask

  task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
    write_hi = wh; write_lo = wl; write_data = d;
    @(posedge clk); #1;
    write_hi = 1'b0; write_lo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk("mt_hi", HI, m_hi);
    chk("mt_lo", LO, m_lo);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts busy cycles, then checks the committed result when busy falls.
  initial begin
    int          cnt;
    bit          moved;
    logic [31:0] h0, l0;
    exp_t        e;
    cnt = 0; moved = 1'b0; h0 = '0; l0 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; moved = 1'b0;
      end else if (busy) begin
        if (cnt == 0) begin
          h0 = HI; l0 = LO;
        end else if (HI !== h0 || LO !== l0) begin
          moved = 1'b1;
        end
        cnt++;
      end else if (cnt != 0) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_commit: got busy window of %0d cycles expected none", cnt);
        end else begin
          e = q.pop_front();
          chk("busy_cycles", 32'(cnt), 32'(e.cyc));
          chk("HI", HI, e.hi);
          chk("LO", LO, e.lo);
          chk("hold_while_busy", 32'(moved), 32'd0);
        end
        cnt = 0; moved = 1'b0;
      end
    end
  end

  initial begin
    logic [3:0] ops[$];
    reset = 1'b1; start = 1'b0; operation = MDUOP_NONE; operand1 = '0; operand2 = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);

    issue(MDUOP_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(MDUOP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(MDUOP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(MDUOP_DIVU,  32'd7,         32'd2, 1'b0);
    mt(1'b1, 1'b0, 32'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    issue(MDUOP_DIVU,  32'd99,        32'd0, 1'b0);
    mt(1'b1, 1'b1, 32'hCAFE_F00D);
    issue(MDUOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(MDUOP_DIV,   32'd100,       32'hFFFF_FFF9, 1'b1);

    // Start wins over a same-cycle mtlo.
    write_lo = 1'b1; write_data = 32'hDEAD;
    issue(MDUOP_MULT, 32'd6, 32'd7, 1'b0);

    // Invalid opcode start is ignored.
    start = 1'b1; operation = 4'd15; operand1 = 32'd5; operand2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; operation = MDUOP_NONE;
    chk("badop_busy", 32'(busy), 32'd0);

`ifdef MDU_MADD_EN
    mt(1'b1, 1'b0, 32'h0);
    mt(1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(MDUOP_MADD, 32'd1, 32'd1, 1'b0);
    mt(1'b1, 1'b1, 32'h0);
    issue(MDUOP_MSUBU, 32'd1, 32'd1, 1'b0);
`else
    start = 1'b1; operation = MDUOP_MADD; operand1 = 32'd1; operand2 = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; operation = MDUOP_NONE;
    chk("madd_off_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("madd_off_HI", HI, m_hi);
    chk("madd_off_LO", LO, m_lo);
`endif

    // Reset in the third busy cycle of a mult aborts it.
    start = 1'b1; operation = MDUOP_MULT; operand1 = 32'd9; operand2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; operation = MDUOP_NONE;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_HI", HI, 32'd0);
    chk("abort_LO", LO, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_nocommit_HI", HI, 32'd0);
    chk("abort_nocommit_LO", LO, 32'd0);

    ops = '{MDUOP_MULT, MDUOP_MULTU, MDUOP_DIV, MDUOP_DIVU};
`ifdef MDU_MADD_EN
    ops.push_back(MDUOP_MADD); ops.push_back(MDUOP_MADDU);
    ops.push_back(MDUOP_MSUB); ops.push_back(MDUOP_MSUBU);
`endif
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) mt(1'b1, $urandom_range(0, 1) == 1, $urandom);
      issue(ops[$urandom_range(0, ops.size() - 1)], rand_opnd(), rand_opnd(),
            $urandom_range(0, 3) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide unit (MDU) for the five-stage MIPS pipeline. It sits beside the ALU in the Execute stage.
- Consumes the forwarded E-stage rs/rt operands and owns the HI/LO registers.
- Exposes busy so hazard control can stall D-stage MDU instructions (mult/multu/div/divu/mthi/mtlo/mfhi/mflo).
- HI/LO values are read by the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family).
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse from E stage for a valid, non-flushed mult/div-class instruction.
- operation  in  `MDUOP_SIZE  operation code from E control.
- operand1  in  32  forwarded E rs data.
- operand2  in  32  forwarded E rt data.
- write_hi  in  1  mthi in E stage.
- write_lo  in  1  mtlo in E stage.
- write_data  in  32  forwarded E rs data for mthi/mtlo.
- busy  out  1  operation in flight.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- Reset: HI=0, LO=0, busy=0, counter=0, state=IDLE. Reset mid-operation aborts the operation; its result is discarded.
- States:
  - IDLE: when start is sampled with a valid op, compute the result into internal hi_pend/lo_pend, load counter=N (N = MULT_CYCLES or DIV_CYCLES), and go to BUSY.
  - BUSY: decrement counter each cycle. On the edge where counter reaches 1, commit HI/LO from pending and return to IDLE.
- Latency: start sampled at edge t0 → busy=1 in cycles t0+1 through t0+N. New HI/LO are visible in cycle t0+N+1, the same cycle busy returns to 0. HI/LO never change while busy=1.
- mult: signed 32x32 → 64-bit; HI=product[63:32], LO=product[31:0].
- multu: same as mult, unsigned.
- div: signed. LO=quotient, truncated toward zero. HI=remainder, which takes the sign of the dividend.
- divu: unsigned; LO=quotient, HI=remainder.
- 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: operation accepted, busy runs the full DIV_CYCLES, HI/LO left unchanged.
- write_hi/write_lo in IDLE with no start: HI/LO := write_data at the next edge. Both may be asserted together; each register updates independently.
- Simultaneous start and write_*: start wins, and the write is dropped.
- start, write_hi or write_lo while busy: ignored. Hazard control guarantees this never occurs; the bench checks that it is ignored.
- start with operation=`MDUOP_NONE or an unsupported code: ignored, busy stays 0.
- Stall contract, implemented in hazard control: stall D when the D instruction is MDU-class and (busy || start).

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds madd, maddu, msub and msubu. {HI,LO} ± product is computed using HI/LO at start time, with MULT_CYCLES latency. madd/msub use a signed product; maddu/msubu use an unsigned product. The 64-bit sum wraps modulo 2^64.
- Undefined: these opcodes decode as unsupported and are ignored as above.

Decomposition:
- Shared macros header (alongside the existing control/forwarding macros):
  - `MDUOP_SIZE (4).
  - `MDUOP_NONE, `MDUOP_MULT, `MDUOP_MULTU, `MDUOP_DIV, `MDUOP_DIVU.
  - `MDUOP_MADD, `MDUOP_MADDU, `MDUOP_MSUB, `MDUOP_MSUBU.
  - `MDU_STATE_IDLE, `MDU_STATE_BUSY.
- No sub-module. Arithmetic is behavioural, using * / % with $signed casts, in one combinational block feeding hi_pend/lo_pend. The FSM and counter live in the same module.

Test Plan:
- Reset, then mult 0xFFFFFFFF×0x00000002 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div 0xFFFFFFF9 (−7) by 0x00000002 → busy exactly 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 by 2 → LO=3, HI=1.
- mthi 0x1234 and mtlo 0x5678 in the same cycle, then divu by 0 → HI=0x1234, LO=0x5678 after 10 busy cycles. Also 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
- During a busy div: a second start of mult 3×3 and write_hi 0xAAAA → both ignored; final HI/LO reflect the div only, and busy falls at cycle 10.
- reset asserted in cycle 3 of a mult → next cycle busy=0, HI=0, LO=0, and no later commit occurs. start together with write_lo → start executes, LO reflects the product.
- MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, madd 1×1 → after 5 cycles HI=1, LO=0. msubu 1×1 from HI=0, LO=0 → HI=LO=0xFFFFFFFF. Macro undefined: a madd start leaves busy=0 and HI/LO unchanged.
